sipo_frame_receiver: RTL and testbench
======================================

SIPO_FRAME_RECEIVER -- requirements
Module: sipo_frame_receiver

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame.
REQ-002 Parameter MSB_FIRST, default 1; 1 means the first data bit on the line is dout[DATA_W-1], 0 means it is dout[0].
REQ-003 Parameter PARITY_EN, default 1; 1 means one even-parity bit follows the data bits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 sin  input  1  serial line; idle level 0; one bit per clk cycle.
REQ-007 dout  output  DATA_W  last delivered payload.
REQ-008 dvalid  output  1  dout and parity_err hold an unconsumed frame.
REQ-009 dready  input  1  consumer accepts dout in any cycle with dvalid=1.
REQ-010 parity_err  output  1  delivered frame failed the even-parity check; always 0 when PARITY_EN=0.
REQ-011 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Frame format on sin: start bit (1), then DATA_W data bits, then the parity bit if PARITY_EN=1; frame length is 1+DATA_W+PARITY_EN cycles.
REQ-014 FSM states: IDLE, DATA, PARITY.
REQ-015 IDLE: sin=1 at a rising edge moves the FSM to DATA and clears bit_cnt; sin=0 stays in IDLE.
REQ-016 DATA: each edge shifts sin into the shift register and increments bit_cnt.
REQ-017 DATA exit: the edge sampling data bit DATA_W-1 moves the FSM to PARITY if PARITY_EN=1, else to IDLE with delivery.
REQ-018 PARITY: the edge sampling the parity bit delivers the frame and returns the FSM to IDLE.
REQ-019 Parity rule: parity_err = XOR of the data bits and the parity bit; even parity means the total count of ones is even.
REQ-020 Delivery updates dout and parity_err from the final-sample edge, including the bit being sampled, and sets dvalid=1 from that same edge.
REQ-021 Latency: with the start bit sampled at edge 0, dvalid is visible after edge DATA_W+PARITY_EN (edge 9 for the default 8-bit frame).
REQ-022 Handshake: dvalid&&dready at an edge clears dvalid, unless a delivery occurs on the same edge.
REQ-023 Simultaneous delivery, dvalid=1 and dready=1: the old frame is consumed, the new frame is loaded, and dvalid stays 1.
REQ-024 Delivery with dvalid=1 and dready=0: the new frame is dropped, dout and parity_err are kept, and overrun pulses high for one cycle.
REQ-025 Back-to-back frames are supported: a start bit on the cycle immediately after the final bit is detected.
REQ-026 While a frame is in progress, sin=1 is treated as data and never as a start bit.
REQ-027 dout and parity_err are stable while dvalid=1 and change only on a delivery edge.
REQ-028 The shift register contents never appear on dout before delivery.

Reset
REQ-029 reset=1 forces: state IDLE, bit_cnt 0, shift register 0, dout 0, dvalid 0, parity_err 0, overrun 0, busy 0.
REQ-030 Reset takes priority over every other event, including a pending delivery or handshake on the same edge.
REQ-031 Reset mid-frame discards the partial frame; the first start bit after reset deasserts begins a clean frame.

Structure
REQ-032 The shared package sipo_pkg holds the FSM state enum (IDLE, DATA, PARITY) and the constants DATA_W_DEFAULT=8 and FRAME_LEN(DATA_W, PARITY_EN).
REQ-033 A single sub-module, sipo_shreg, holds the shift register (parameterised DATA_W and MSB_FIRST, with shift_en and clear inputs).
REQ-034 The top level owns the FSM, bit_cnt, parity accumulator, output register and handshake logic.

Verification
REQ-035 Idle line: reset, sin=0 for 50 cycles -> dvalid, busy and overrun stay 0.
REQ-036 Single frame: send start bit, then 0xA5 MSB-first, then parity 0, with dready=0 -> dout=0xA5, parity_err=0, dvalid=1 after edge 9, dvalid held; then dready=1 for one cycle -> dvalid=0.
REQ-037 Bad parity: send 0x3C with parity 1 -> dout=0x3C, parity_err=1.
REQ-038 Overrun: send 0x11 then 0x22 back-to-back with dready=0 -> dout stays 0x11, overrun pulses exactly one cycle at the second delivery.
REQ-039 Simultaneous handshake: hold dready=1 from the cycle the first frame is delivered, send 0x11 then 0x22 -> dvalid stays 1, dout becomes 0x22, no overrun.
REQ-040 Reset mid-frame: assert reset after 4 data bits of 0xFF, then send 0x5A -> dout=0x5A, with no intermediate delivery or overrun.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in frame receiver.
package sipo_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DATA_W_DEFAULT = 8;

  // Line cycles per frame: start bit, payload, optional parity bit
  function automatic int FRAME_LEN(input int data_w, input int parity_en);
    return 1 + data_w + parity_en;
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Payload shift register; shift direction chosen so that the first bit on
// the line lands in dout[DATA_W-1] (MSB_FIRST=1) or dout[0] (MSB_FIRST=0).
module sipo_shreg #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              sin,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] q_shift
);

  // q_shift is the value q would take if sin were shifted in this cycle;
  // the top uses it to deliver a frame whose final bit is the one being sampled.
  generate
    if (DATA_W == 1) begin : g_single
      assign q_shift = sin;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign q_shift = {q[DATA_W-2:0], sin};
    end else begin : g_lsb
      assign q_shift = {sin, q[DATA_W-1:1]};
    end
  endgenerate

  // Register update: reset and clear dominate shifting
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= q_shift;
    end
  end

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W payload bits, optional even parity.
// Completed frames are presented on dout with a valid/ready handshake.
//
//   state  | meaning
//   IDLE   | waiting for a start bit (sin=1)
//   DATA   | sampling payload bits, bit_cnt counts bits taken so far
//   PARITY | sampling the parity bit; this edge delivers the frame
module sipo_frame_receiver
  import sipo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  input  logic              dready,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic               parity_acc;
  logic               shift_en;
  logic               sh_clear;
  logic               deliver;
  logic               last_bit;
  logic [DATA_W-1:0]  sh_q;
  logic [DATA_W-1:0]  sh_shift;
  logic [DATA_W-1:0]  word_nxt;
  logic               perr_nxt;

  sipo_shreg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .clear    (sh_clear),
    .shift_en (shift_en),
    .sin      (sin),
    .q        (sh_q),
    .q_shift  (sh_shift)
  );

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    sh_clear  = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE: begin
        if (sin) begin
          state_nxt = DATA;
          sh_clear  = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (last_bit) begin
          if (PARITY_EN != 0) begin
            state_nxt = PARITY;
          end else begin
            state_nxt = IDLE;
            deliver   = 1'b1;
          end
        end
      end
      PARITY: begin
        deliver   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Payload bit counter, restarted by each start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (state == IDLE && sin) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Running XOR of payload bits; the parity bit is folded in at delivery
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_acc <= 1'b0;
    end else if (state == IDLE && sin) begin
      parity_acc <= 1'b0;
    end else if (shift_en) begin
      parity_acc <= parity_acc ^ sin;
    end
  end

  // Without parity the last payload bit is still on sin at delivery,
  // so take the post-shift view of the register in that case.
  assign word_nxt = (state == PARITY) ? sh_q : sh_shift;
  assign perr_nxt = (PARITY_EN != 0) ? (parity_acc ^ sin) : 1'b0;

  // Output register, handshake and overrun detection
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      parity_err <= 1'b0;
      dvalid     <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      if (!dvalid || dready) begin
        dout       <= word_nxt;
        parity_err <= perr_nxt;
        dvalid     <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun    <= 1'b1;
      end
    end else begin
      overrun <= 1'b0;
      if (dvalid && dready) begin
        dvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver: table of frames plus hand-written
// overrun, simultaneous-handshake and reset sequences.
module tb_sipo_frame_receiver;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_perr;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       sin;
  logic       dready;
  logic [7:0] dout;
  logic       dvalid;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  logic       sin2;
  logic       dready2;
  logic [7:0] dout2;
  logic       dvalid2;
  logic       parity_err2;
  logic       overrun2;
  logic       busy2;

  int vectors;
  int fails;
  int ovr_seen;

  vec_t vtab [6];

  sipo_frame_receiver #(.DATA_W(8), .MSB_FIRST(1), .PARITY_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin),
    .dout       (dout),
    .dvalid     (dvalid),
    .dready     (dready),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  sipo_frame_receiver #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(0)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .sin        (sin2),
    .dout       (dout2),
    .dvalid     (dvalid2),
    .dready     (dready2),
    .parity_err (parity_err2),
    .overrun    (overrun2),
    .busy       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (overrun) ovr_seen++;
  endtask

  // Start bit, 8 bits MSB first, parity bit; dready applied on the final edge
  task automatic send_frame(input logic [7:0] data, input logic par,
                            input logic ready_last, output logic dv_before);
    logic [7:0] d;
    d = data;
    sin = 1'b1;
    tick();
    for (int i = 7; i >= 0; i--) begin
      sin = d[i];
      tick();
    end
    dv_before = dvalid;
    sin = par;
    dready = ready_last;
    tick();
    sin = 1'b0;
  endtask

  initial begin
    logic       dvb;
    logic [7:0] w;
    vectors  = 0;
    fails    = 0;
    ovr_seen = 0;

    vtab[0] = '{8'hA5, 1'b0, 1'b0};
    vtab[1] = '{8'h3C, 1'b1, 1'b1};
    vtab[2] = '{8'hFF, 1'b0, 1'b0};
    vtab[3] = '{8'h01, 1'b1, 1'b0};
    vtab[4] = '{8'h80, 1'b0, 1'b1};
    vtab[5] = '{8'h7E, 1'b1, 1'b1};

    reset   = 1'b1;
    sin     = 1'b0;
    dready  = 1'b0;
    sin2    = 1'b0;
    dready2 = 1'b0;
    tick();
    tick();
    chk("rst_dout",   32'(dout),       32'h0);
    chk("rst_dvalid", 32'(dvalid),     32'h0);
    chk("rst_perr",   32'(parity_err), 32'h0);
    chk("rst_ovr",    32'(overrun),    32'h0);
    chk("rst_busy",   32'(busy),       32'h0);
    reset = 1'b0;

    // Idle line
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_flags", 32'({dvalid, busy, overrun}), 32'h0);
    end

    // Table of single frames, each consumed after a hold period
    for (int k = 0; k < 6; k++) begin
      dready = 1'b0;
      send_frame(vtab[k].data, vtab[k].par, 1'b0, dvb);
      chk("tab_dvalid_edge8", 32'(dvb), 32'h0);
      chk("tab_dvalid_edge9", 32'(dvalid), 32'h1);
      chk("tab_dout", 32'(dout), 32'(vtab[k].data));
      chk("tab_perr", 32'(parity_err), 32'(vtab[k].exp_perr));
      chk("tab_busy_after", 32'(busy), 32'h0);
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("tab_hold", 32'({dvalid, dout}), 32'({1'b1, vtab[k].data}));
      end
      dready = 1'b1;
      tick();
      chk("tab_consume", 32'(dvalid), 32'h0);
      dready = 1'b0;
    end

    // Overrun: second back-to-back frame dropped with dready low
    ovr_seen = 0;
    send_frame(8'h11, 1'b0, 1'b0, dvb);
    chk("ovr_first_dout", 32'(dout), 32'h11);
    send_frame(8'h22, 1'b0, 1'b0, dvb);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_dout_kept", 32'(dout), 32'h11);
    tick();
    chk("ovr_pulse_end", 32'(overrun), 32'h0);
    chk("ovr_count", 32'(ovr_seen), 32'h1);
    chk("ovr_dvalid", 32'(dvalid), 32'h1);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("ovr_consume", 32'(dvalid), 32'h0);

    // Consume and reload on the same edge
    ovr_seen = 0;
    send_frame(8'h11, 1'b0, 1'b0, dvb);
    send_frame(8'h22, 1'b0, 1'b1, dvb);
    chk("sim_dvalid", 32'(dvalid), 32'h1);
    chk("sim_dout", 32'(dout), 32'h22);
    chk("sim_no_ovr", 32'(ovr_seen), 32'h0);
    tick();
    chk("sim_consume", 32'(dvalid), 32'h0);
    dready = 1'b0;

    // Reset mid-frame after 4 payload ones
    sin = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    sin   = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    ovr_seen = 0;
    send_frame(8'h5A, 1'b0, 1'b0, dvb);
    chk("mid_no_early", 32'(dvb), 32'h0);
    chk("mid_dout", 32'(dout), 32'h5A);
    chk("mid_perr", 32'(parity_err), 32'h0);
    chk("mid_no_ovr", 32'(ovr_seen), 32'h0);
    dready = 1'b1;
    tick();
    dready = 1'b0;

    // Reset wins over a delivery on the same edge
    sin = 1'b1;
    tick();
    w = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      sin = w[i];
      tick();
    end
    sin   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstpri_dvalid", 32'(dvalid), 32'h0);
    chk("rstpri_dout", 32'(dout), 32'h0);

    // LSB-first, no-parity instance: delivery after edge 8
    w = 8'h3A;
    sin2 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("lsb_dvalid_edge7", 32'(dvalid2), 32'h0);
      sin2 = w[i];
      tick();
    end
    sin2 = 1'b0;
    chk("lsb_dvalid_edge8", 32'(dvalid2), 32'h1);
    chk("lsb_dout", 32'(dout2), 32'h3A);
    chk("lsb_perr", 32'(parity_err2), 32'h0);
    dready2 = 1'b1;
    tick();
    dready2 = 1'b0;
    chk("lsb_consume", 32'(dvalid2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
